// File: rtl/spi_defs_pkg.sv
// Shared SPI master definitions: FSM state encoding and mode-0 line levels.
// Used by spi_master_engine and spi_clk_div.
package spi_defs_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } spi_state_e;

  // Mode 0: SCK idles low, data launched on the falling edge, sampled on the rising edge.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_IDLE_SCK  = SPI_CPOL;
  localparam logic SPI_IDLE_MOSI = 1'b1;
  localparam logic SPI_IDLE_CS_N = 1'b1;

  // Width of a counter able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter that marks the last cycle of an SPI clock phase.
// A phase loaded with value v lasts v+1 cycles; tick is high in its final cycle.
module spi_clk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master_engine.sv
// Full-duplex mode-0 SPI master with valid/ready word interface and chip-select ownership.
// Optional response start-bit hunt is built when SPI_RESP_HUNT_EN is defined.
module spi_master_engine
  import spi_defs_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned HUNT_MAX = 16
) (
  input  logic              SCLK,
  input  logic              RST,
  input  logic [DIV_W-1:0]  DIV,
  input  logic              CS_HOLD,
  input  logic              TX_VALID,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_READY,
  output logic              RX_VALID,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              BUSY,
  input  logic              HUNT,
  output logic              HUNT_TO,
  output logic              SPI_SCK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_CS_N
);

  localparam int unsigned BitCntW = cnt_width(DATA_W);

  spi_state_e          state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DIV_W-1:0]    div_q;
  logic                cs_hold_q;
  logic [BitCntW-1:0]  bit_cnt_q;

  logic                accept;
  logic                phase_active;
  logic                last_bit;
  logic                tick;
  logic                div_load;
  logic [DIV_W-1:0]    div_value;
  logic                hunt_more;
  logic                hunt_timeout;

  assign accept       = TX_VALID && TX_READY;
  assign phase_active = (state_q == StLow) || (state_q == StHigh);
  assign last_bit     = (bit_cnt_q == BitCntW'(DATA_W));

  // Each phase end reloads the divider so the next phase starts a full DIV+1 count.
  assign div_load  = accept || (phase_active && tick);
  assign div_value = accept ? DIV : div_q;

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk   (SCLK),
    .rst   (RST),
    .load  (div_load),
    .value (div_value),
    .tick  (tick)
  );

`ifdef SPI_RESP_HUNT_EN
  localparam int unsigned WordCntW = cnt_width(HUNT_MAX);

  logic                hunt_q;
  logic [WordCntW-1:0] word_cnt_q;
  logic                hunt_to_q;

  // A received MSB of 1 means the card has not started its response yet.
  assign hunt_more    = hunt_q && shift_q[DATA_W-1] && (word_cnt_q < WordCntW'(HUNT_MAX));
  assign hunt_timeout = hunt_q && shift_q[DATA_W-1];
  assign HUNT_TO      = hunt_to_q;

  always_ff @(posedge SCLK) begin
    if (RST) begin
      hunt_q     <= 1'b0;
      word_cnt_q <= '0;
      hunt_to_q  <= 1'b0;
    end else begin
      hunt_to_q <= 1'b0;
      if ((state_q == StIdle || state_q == StDone) && accept) begin
        hunt_q     <= HUNT;
        word_cnt_q <= WordCntW'(1);
      end else if (state_q == StHigh && tick && last_bit) begin
        if (hunt_more) begin
          word_cnt_q <= word_cnt_q + WordCntW'(1);
        end else begin
          hunt_to_q <= hunt_timeout;
        end
      end
    end
  end
`else
  logic unused_hunt;

  assign unused_hunt  = HUNT;
  assign hunt_more    = 1'b0;
  assign hunt_timeout = 1'b0;
  assign HUNT_TO      = 1'b0;
`endif

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      div_q     <= '0;
      cs_hold_q <= 1'b0;
      bit_cnt_q <= '0;
      TX_READY  <= 1'b1;
      RX_VALID  <= 1'b0;
      RX_DATA   <= '0;
      BUSY      <= 1'b0;
      SPI_SCK   <= SPI_IDLE_SCK;
      SPI_MOSI  <= SPI_IDLE_MOSI;
      SPI_CS_N  <= SPI_IDLE_CS_N;
    end else begin
      RX_VALID <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q   <= StLow;
            div_q     <= DIV;
            cs_hold_q <= CS_HOLD;
            bit_cnt_q <= '0;
            TX_READY  <= 1'b0;
            BUSY      <= 1'b1;
            SPI_SCK   <= SPI_IDLE_SCK;
            SPI_CS_N  <= 1'b0;
`ifdef SPI_RESP_HUNT_EN
            if (HUNT) begin
              shift_q  <= '1;
              SPI_MOSI <= 1'b1;
            end else begin
              shift_q  <= TX_DATA;
              SPI_MOSI <= TX_DATA[DATA_W-1];
            end
`else
            shift_q  <= TX_DATA;
            SPI_MOSI <= TX_DATA[DATA_W-1];
`endif
          end else if (state_q == StDone) begin
            state_q  <= StIdle;
            SPI_MOSI <= SPI_IDLE_MOSI;
            if (!cs_hold_q) begin
              SPI_CS_N <= SPI_IDLE_CS_N;
            end
          end
        end

        StLow: begin
          if (tick) begin
            state_q   <= StHigh;
            SPI_SCK   <= 1'b1;
            shift_q   <= {shift_q[DATA_W-2:0], SPI_MISO};
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end

        StHigh: begin
          if (tick) begin
            SPI_SCK <= 1'b0;
            if (!last_bit) begin
              // The shift left on the rising edge already moved the next TX bit to the top.
              state_q  <= StLow;
              SPI_MOSI <= shift_q[DATA_W-1];
            end else if (hunt_more) begin
              state_q   <= StLow;
              shift_q   <= '1;
              bit_cnt_q <= '0;
              SPI_MOSI  <= 1'b1;
            end else begin
              state_q  <= StDone;
              RX_VALID <= 1'b1;
              RX_DATA  <= shift_q;
              TX_READY <= 1'b1;
              BUSY     <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: random words checked against a word-level SPI model.
// The hunt scenarios are compiled in when SPI_RESP_HUNT_EN is defined.
module tb_spi_master_engine;

  localparam int W  = 8;
  localparam int DW = 8;
  localparam int MEM = 4096;

  logic          SCLK = 1'b0;
  logic          RST  = 1'b1;
  logic [DW-1:0] DIV  = '0;
  logic          CS_HOLD  = 1'b0;
  logic          TX_VALID = 1'b0;
  logic [W-1:0]  TX_DATA  = '0;
  logic          HUNT     = 1'b0;
  logic          TX_READY, RX_VALID, BUSY, HUNT_TO;
  logic [W-1:0]  RX_DATA;
  logic          SPI_SCK, SPI_MOSI, SPI_MISO, SPI_CS_N;

  int checks = 0;
  int errors = 0;

  // Slave side: miso_mem is the bit stream the card returns, one bit per SCK rise.
  int           cyc = 0;
  int           sck_cnt = 0;
  bit           miso_mem [MEM];
  bit           mosi_mem [MEM];
  int           rise_cyc [MEM];
  int           rx_cnt = 0;
  int           rx_cyc = 0;
  logic [W-1:0] rx_last = '0;
  logic         rx_to = 1'b0;

  spi_master_engine #(
    .DATA_W   (W),
    .DIV_W    (DW),
    .HUNT_MAX (16)
  ) dut (
    .SCLK     (SCLK),
    .RST      (RST),
    .DIV      (DIV),
    .CS_HOLD  (CS_HOLD),
    .TX_VALID (TX_VALID),
    .TX_DATA  (TX_DATA),
    .TX_READY (TX_READY),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .BUSY     (BUSY),
    .HUNT     (HUNT),
    .HUNT_TO  (HUNT_TO),
    .SPI_SCK  (SPI_SCK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .SPI_CS_N (SPI_CS_N)
  );

  always #5 SCLK = ~SCLK;

  always @(posedge SCLK) cyc <= cyc + 1;

  assign SPI_MISO = miso_mem[sck_cnt % MEM];

  always @(posedge SPI_SCK) begin
    mosi_mem[sck_cnt % MEM] <= SPI_MOSI;
    rise_cyc[sck_cnt % MEM] <= cyc;
    sck_cnt <= sck_cnt + 1;
  end

  always @(negedge SCLK) begin
    if (RX_VALID === 1'b1) begin
      rx_cnt  <= rx_cnt + 1;
      rx_cyc  <= cyc;
      rx_last <= RX_DATA;
      rx_to   <= HUNT_TO;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Queue word index k (MSB first) as the card reply after the current SCK count.
  task automatic load_miso(input logic [W-1:0] w, input int k);
    for (int i = 0; i < W; i++) miso_mem[(sck_cnt + k * W + i) % MEM] = w[W-1-i];
  endtask

  function automatic logic [W-1:0] mosi_word(input int p);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = mosi_mem[(p + i) % MEM];
    return r;
  endfunction

  // Offers one word; returns the index of the accepting edge. Inputs are scrambled afterwards.
  task automatic run_word(input logic [W-1:0] d, input int div, input bit hold, input bit hunt,
                          output int t_acc);
    int n = 0;
    @(negedge SCLK);
    while (TX_READY !== 1'b1 && n < 2000) begin
      @(negedge SCLK);
      n++;
    end
    TX_DATA  = d;
    DIV      = DW'(div);
    CS_HOLD  = hold;
    HUNT     = hunt;
    TX_VALID = 1'b1;
    t_acc    = cyc + 1;
    @(posedge SCLK);
    #1;
    TX_VALID = 1'b0;
    HUNT     = 1'b0;
    TX_DATA  = W'($urandom);
    DIV      = DW'($urandom);
    CS_HOLD  = 1'($urandom);
  endtask

  task automatic wait_rx(input int start, input int budget, output int bad_ready);
    int n = 0;
    bad_ready = 0;
    while (rx_cnt == start && n < budget) begin
      @(negedge SCLK);
      #1;
      n++;
      if (rx_cnt == start && TX_READY !== 1'b0) bad_ready++;
    end
    checks++;
    if (rx_cnt == start) begin
      errors++;
      $display("FAIL rx_timeout: rx_cnt=%0d after %0d cycles, required > %0d", rx_cnt, n, start);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge SCLK);
    @(negedge SCLK);
    RST = 1'b0;
    @(negedge SCLK);
    #1;
    checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", TX_READY); end
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", RX_VALID); end
    checks++; if (RX_DATA !== '0) begin errors++; $display("FAIL reset_rx_data: got %h required 00", RX_DATA); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", BUSY); end
    checks++; if (HUNT_TO !== 1'b0) begin errors++; $display("FAIL reset_hunt_to: got %b required 0", HUNT_TO); end
    checks++; if (SPI_SCK !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b required 0", SPI_SCK); end
    checks++; if (SPI_MOSI !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b required 1", SPI_MOSI); end
    checks++; if (SPI_CS_N !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b required 1", SPI_CS_N); end
  endtask

  task automatic test_basic();
    int p0, t, bad, start;
    p0 = sck_cnt;
    start = rx_cnt;
    load_miso(8'h3C, 0);
    run_word(8'hA5, 0, 1'b0, 1'b0, t);
    wait_rx(start, 200, bad);
    checks++; if (mosi_word(p0) !== 8'hA5) begin errors++; $display("FAIL basic_mosi: got %h required a5", mosi_word(p0)); end
    checks++; if (rx_last !== 8'h3C) begin errors++; $display("FAIL basic_rx: got %h required 3c", rx_last); end
    checks++; if (rx_cyc - t != 16) begin errors++; $display("FAIL basic_latency: got %0d required 16", rx_cyc - t); end
    checks++; if (sck_cnt - p0 != 8) begin errors++; $display("FAIL basic_pulses: got %0d required 8", sck_cnt - p0); end
    checks++; if (SPI_CS_N !== 1'b0) begin errors++; $display("FAIL basic_cs_done: got %b required 0", SPI_CS_N); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_ready_busy: got %0d ready cycles required 0", bad); end
    @(negedge SCLK);
    #1;
    checks++;
    if ({SPI_CS_N, SPI_MOSI, RX_VALID, TX_READY} !== 4'b1101) begin
      errors++;
      $display("FAIL basic_after_done: cs_n/mosi/rx_valid/ready got %b required 1101",
               {SPI_CS_N, SPI_MOSI, RX_VALID, TX_READY});
    end
    checks++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL basic_rx_hold: got %h required 3c", RX_DATA); end
  endtask

  task automatic test_div3();
    int p0, t, bad, start;
    logic [W-1:0] d, m;
    d = W'($urandom);
    m = W'($urandom);
    p0 = sck_cnt;
    start = rx_cnt;
    load_miso(m, 0);
    run_word(d, 3, 1'b0, 1'b0, t);
    wait_rx(start, 500, bad);
    checks++; if (rx_cyc - t != 64) begin errors++; $display("FAIL div3_latency: got %0d required 64", rx_cyc - t); end
    checks++; if (rise_cyc[(p0 + 1) % MEM] - rise_cyc[p0 % MEM] != 8) begin
      errors++; $display("FAIL div3_period: got %0d required 8", rise_cyc[(p0 + 1) % MEM] - rise_cyc[p0 % MEM]);
    end
    checks++; if (rx_last !== m) begin errors++; $display("FAIL div3_rx: got %h required %h", rx_last, m); end
    checks++; if (mosi_word(p0) !== d) begin errors++; $display("FAIL div3_mosi: got %h required %h", mosi_word(p0), d); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int p0, t, bad, start, div;
      bit hunt;
      logic [W-1:0] d, m;
      d = W'($urandom);
      m = W'($urandom);
      div = $urandom_range(0, 3);
      hunt = 1'b0;
`ifndef SPI_RESP_HUNT_EN
      hunt = 1'($urandom);
`endif
      p0 = sck_cnt;
      start = rx_cnt;
      load_miso(m, 0);
      run_word(d, div, 1'b0, hunt, t);
      wait_rx(start, 1000, bad);
      checks++; if (rx_last !== m) begin errors++; $display("FAIL rand_rx[%0d]: got %h required %h", it, rx_last, m); end
      checks++; if (mosi_word(p0) !== d) begin errors++; $display("FAIL rand_mosi[%0d]: got %h required %h", it, mosi_word(p0), d); end
      checks++; if (rx_cyc - t != 2 * W * (div + 1)) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", it, rx_cyc - t, 2 * W * (div + 1));
      end
      checks++; if (sck_cnt - p0 != W) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d required %0d", it, sck_cnt - p0, W); end
      checks++; if (rx_to !== 1'b0) begin errors++; $display("FAIL rand_hunt_to[%0d]: got %b required 0", it, rx_to); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_ready_busy[%0d]: got %0d required 0", it, bad); end
      @(negedge SCLK);
      #1;
      checks++; if (SPI_CS_N !== 1'b1) begin errors++; $display("FAIL rand_cs_release[%0d]: got %b required 1", it, SPI_CS_N); end
    end
  endtask

  task automatic test_back_to_back();
    int p0, t1, start, n, cs_glitch, ready_cyc, div, len;
    logic [W-1:0] m1, m2;
    m1 = W'($urandom);
    m2 = W'($urandom);
    div = $urandom_range(0, 2);
    len = 2 * W * (div + 1);
    p0 = sck_cnt;
    start = rx_cnt;
    load_miso(m1, 0);
    load_miso(m2, 1);
    @(negedge SCLK);
    TX_DATA  = 8'h40;
    DIV      = DW'(div);
    CS_HOLD  = 1'b1;
    TX_VALID = 1'b1;
    t1 = cyc + 1;
    @(posedge SCLK);
    #1;
    // Second word offered immediately; it must wait for the first word's DONE cycle.
    TX_DATA = 8'h00;
    CS_HOLD = 1'b0;
    n = 0;
    cs_glitch = 0;
    ready_cyc = -1;
    while (rx_cnt < start + 2 && n < 1000) begin
      @(negedge SCLK);
      #1;
      n++;
      if (SPI_CS_N !== 1'b0) cs_glitch++;
      if (TX_VALID && TX_READY === 1'b1) begin
        ready_cyc = cyc;
        @(posedge SCLK);
        #1;
        TX_VALID = 1'b0;
      end
    end
    checks++; if (rx_cnt != start + 2) begin errors++; $display("FAIL b2b_rx_count: got %0d required %0d", rx_cnt - start, 2); end
    checks++; if (ready_cyc != t1 + len) begin errors++; $display("FAIL b2b_accept_cycle: got %0d required %0d", ready_cyc, t1 + len); end
    checks++; if (cs_glitch != 0) begin errors++; $display("FAIL b2b_cs_gap: got %0d high cycles required 0", cs_glitch); end
    checks++; if (sck_cnt - p0 != 16) begin errors++; $display("FAIL b2b_pulses: got %0d required 16", sck_cnt - p0); end
    checks++; if ({mosi_word(p0), mosi_word(p0 + W)} !== 16'h4000) begin
      errors++; $display("FAIL b2b_mosi: got %h required 4000", {mosi_word(p0), mosi_word(p0 + W)});
    end
    checks++; if (rx_last !== m2) begin errors++; $display("FAIL b2b_rx2: got %h required %h", rx_last, m2); end
    checks++; if (rx_cyc != ready_cyc + 1 + len) begin errors++; $display("FAIL b2b_latency2: got %0d required %0d", rx_cyc, ready_cyc + 1 + len); end
    @(negedge SCLK);
    #1;
    checks++; if (SPI_CS_N !== 1'b1) begin errors++; $display("FAIL b2b_cs_release: got %b required 1", SPI_CS_N); end
  endtask

  task automatic test_reset_mid();
    int p0, t, n, start;
    p0 = sck_cnt;
    start = rx_cnt;
    load_miso(W'($urandom), 0);
    run_word(W'($urandom), $urandom_range(0, 2), 1'b0, 1'b0, t);
    n = 0;
    while (sck_cnt - p0 < 5 && n < 200) begin
      @(negedge SCLK);
      n++;
    end
    RST = 1'b1;
    @(posedge SCLK);
    #1;
    checks++; if (SPI_SCK !== 1'b0) begin errors++; $display("FAIL rstmid_sck: got %b required 0", SPI_SCK); end
    checks++; if (SPI_CS_N !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b required 1", SPI_CS_N); end
    checks++; if (SPI_MOSI !== 1'b1) begin errors++; $display("FAIL rstmid_mosi: got %b required 1", SPI_MOSI); end
    checks++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", TX_READY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", BUSY); end
    checks++; if (RX_DATA !== '0) begin errors++; $display("FAIL rstmid_rx_data: got %h required 00", RX_DATA); end
    @(negedge SCLK);
    RST = 1'b0;
    repeat (100) @(negedge SCLK);
    #1;
    checks++; if (rx_cnt != start) begin errors++; $display("FAIL rstmid_no_rx: got %0d pulses required 0", rx_cnt - start); end
    checks++; if (sck_cnt - p0 != 5) begin errors++; $display("FAIL rstmid_pulses: got %0d required 5", sck_cnt - p0); end
  endtask

`ifdef SPI_RESP_HUNT_EN
  task automatic test_hunt();
    int p0, t, bad, start, div;
    div = $urandom_range(0, 1);
    p0 = sck_cnt;
    start = rx_cnt;
    load_miso(8'hFF, 0);
    load_miso(8'hFF, 1);
    load_miso(8'h01, 2);
    run_word(W'($urandom), div, 1'b0, 1'b1, t);
    wait_rx(start, 2000, bad);
    repeat (5) @(negedge SCLK);
    #1;
    checks++; if (sck_cnt - p0 != 24) begin errors++; $display("FAIL hunt_pulses: got %0d required 24", sck_cnt - p0); end
    checks++; if (rx_cnt != start + 1) begin errors++; $display("FAIL hunt_rx_count: got %0d required 1", rx_cnt - start); end
    checks++; if (rx_last !== 8'h01) begin errors++; $display("FAIL hunt_rx: got %h required 01", rx_last); end
    checks++; if (rx_to !== 1'b0) begin errors++; $display("FAIL hunt_to: got %b required 0", rx_to); end
    checks++; if (rx_cyc - t != 3 * 2 * W * (div + 1)) begin
      errors++; $display("FAIL hunt_latency: got %0d required %0d", rx_cyc - t, 3 * 2 * W * (div + 1));
    end
    checks++; if ({mosi_word(p0), mosi_word(p0 + W), mosi_word(p0 + 2 * W)} !== 24'hFFFFFF) begin
      errors++; $display("FAIL hunt_mosi: got %h required ffffff", {mosi_word(p0), mosi_word(p0 + W), mosi_word(p0 + 2 * W)});
    end

    p0 = sck_cnt;
    start = rx_cnt;
    for (int k = 0; k < 18; k++) load_miso(8'hFF, k);
    run_word(W'($urandom), 0, 1'b0, 1'b1, t);
    wait_rx(start, 2000, bad);
    repeat (5) @(negedge SCLK);
    #1;
    checks++; if (sck_cnt - p0 != 16 * W) begin errors++; $display("FAIL hunt_stuck_pulses: got %0d required %0d", sck_cnt - p0, 16 * W); end
    checks++; if (rx_cnt != start + 1) begin errors++; $display("FAIL hunt_stuck_count: got %0d required 1", rx_cnt - start); end
    checks++; if (rx_last !== 8'hFF) begin errors++; $display("FAIL hunt_stuck_rx: got %h required ff", rx_last); end
    checks++; if (rx_to !== 1'b1) begin errors++; $display("FAIL hunt_stuck_to: got %b required 1", rx_to); end
    checks++; if (SPI_CS_N !== 1'b1) begin errors++; $display("FAIL hunt_stuck_cs: got %b required 1", SPI_CS_N); end
  endtask
`endif

  initial begin
    for (int i = 0; i < MEM; i++) miso_mem[i] = 1'b1;
    test_reset();
    test_basic();
    test_div3();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_RESP_HUNT_EN
    test_hunt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
